// File: rtl/rv_wb_pkg.sv
// Shared writeback definitions: datapath widths and requester indices.
package rv_wb_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  localparam int WB_ALU  = 0;
  localparam int WB_LOAD = 1;
  localparam int WB_CSR  = 2;
  localparam int WB_N    = 3;

endpackage

// File: rtl/regfile_wb_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker. The search starts at ptr and wraps,
// returning a one-hot grant, its index, and whether anything was requesting.
module rr_pick #(
  parameter int N  = 3,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] idx,
  output logic          any
);

  // Walk the offsets from farthest to nearest so the nearest requester wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      int j;
      j = (int'(ptr) + k) % N;
      if (req[j]) begin
        grant    = '0;
        grant[j] = 1'b1;
        idx      = PW'(j);
        any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port among writeback requesters.
// Optional WB_ARB_PERF_EN adds a saturating conflict_cnt output.
module regfile_wb_arbiter
  import rv_wb_pkg::*;
#(
  parameter int N_REQ  = WB_N,
  parameter int DATA_W = XLEN,
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic                    clk,
  input  logic                    async_reset,
  input  logic                    flush,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        req_ready,
  output logic                    wr_en,
  output logic [ADDR_W-1:0]       wr_addr,
  output logic [DATA_W-1:0]       wr_data
`ifdef WB_ARB_PERF_EN
  , output logic [31:0]           conflict_cnt
`endif
);

  localparam int PW = $clog2(N_REQ);

  logic [PW-1:0]     ptr_reg;
  logic [PW-1:0]     ptr_next;
  logic [N_REQ-1:0]  pick_grant;
  logic [PW-1:0]     pick_idx;
  logic              pick_any;
  logic              xfer;
  logic [ADDR_W-1:0] addr_arr [N_REQ];
  logic [DATA_W-1:0] data_arr [N_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign addr_arr[gi] = req_addr[gi*ADDR_W +: ADDR_W];
      assign data_arr[gi] = req_data[gi*DATA_W +: DATA_W];
    end
  endgenerate

  rr_pick #(.N(N_REQ), .PW(PW)) u_pick (
    .req   (req_valid),
    .ptr   (ptr_reg),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // Ready is masked by reset as well so nothing looks accepted while state is being cleared.
  assign xfer      = pick_any && !flush && !async_reset;
  assign req_ready = xfer ? pick_grant : '0;
  assign ptr_next  = (pick_idx == PW'(N_REQ - 1)) ? '0 : pick_idx + PW'(1);

  always_ff @(posedge clk or posedge async_reset) begin
    if (async_reset) begin
      ptr_reg <= '0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else if (xfer) begin
      // Writes to x0 are accepted but never reach the register file.
      wr_en   <= (addr_arr[pick_idx] != '0);
      wr_addr <= addr_arr[pick_idx];
      wr_data <= data_arr[pick_idx];
      ptr_reg <= ptr_next;
    end else begin
      wr_en <= 1'b0;
    end
  end

`ifdef WB_ARB_PERF_EN
  always_ff @(posedge clk or posedge async_reset) begin
    if (async_reset) begin
      conflict_cnt <= '0;
    end else if (!flush && ($countones(req_valid) >= 2) && (conflict_cnt != '1)) begin
      conflict_cnt <= conflict_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed table, hand-written reset/flush
// sequences, and a randomized run against a queue-free behavioural model.
module tb_regfile_wb_arbiter;

  localparam int N  = 3;
  localparam int AW = 5;
  localparam int DW = 32;

  logic            clk;
  logic            async_reset;
  logic            flush;
  logic [N-1:0]    req_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [DW-1:0]   wr_data;
`ifdef WB_ARB_PERF_EN
  logic [31:0]     conflict_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  int            m_ptr;
  logic          m_wr_en;
  logic [AW-1:0] m_wr_addr;
  logic [DW-1:0] m_wr_data;
  logic [31:0]   m_cnt;

  regfile_wb_arbiter #(.N_REQ(N), .DATA_W(DW), .ADDR_W(AW)) dut (
    .clk          (clk),
    .async_reset  (async_reset),
    .flush        (flush),
    .req_valid    (req_valid),
    .req_addr     (req_addr),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data)
`ifdef WB_ARB_PERF_EN
    , .conflict_cnt (conflict_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [N-1:0]    valid;
    logic            flush;
    logic [N*AW-1:0] addr;
    logic [N*DW-1:0] data;
    logic [N-1:0]    exp_ready;
    logic            exp_wr_en;
    logic [AW-1:0]   exp_wr_addr;
    logic [DW-1:0]   exp_wr_data;
  } vec_t;

  vec_t tbl [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Round-robin rule: first valid requester at or after ptr, wrapping; -1 if none.
  function automatic int model_grant(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) begin
      if (v[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  function automatic vec_t mkv(input logic [N-1:0] v, input logic f, input logic [N*AW-1:0] a,
                               input logic [N*DW-1:0] d, input logic [N-1:0] er, input logic ee,
                               input logic [AW-1:0] ea, input logic [DW-1:0] ed);
    vec_t r;
    r.valid = v; r.flush = f; r.addr = a; r.data = d;
    r.exp_ready = er; r.exp_wr_en = ee; r.exp_wr_addr = ea; r.exp_wr_data = ed;
    return r;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_wr_en = 1'b0; m_wr_addr = '0; m_wr_data = '0; m_cnt = '0;
  endtask

  // Reset held across one edge, released between edges (posedge + 1).
  task automatic do_reset();
    req_valid = '0; flush = 1'b0;
    async_reset = 1'b1;
    @(posedge clk); #1;
    async_reset = 1'b0;
    model_reset();
  endtask

  logic [N*AW-1:0] all_addr;
  logic [N*DW-1:0] all_data;
  logic [N-1:0]    pend;
  logic [AW-1:0]   r_addr [N];
  logic [DW-1:0]   r_data [N];

  initial begin
    async_reset = 1'b1;
    flush       = 1'b0;
    req_valid   = '0;
    req_addr    = '0;
    req_data    = '0;
    all_addr    = {5'd3, 5'd2, 5'd1};
    all_data    = {32'h102, 32'h101, 32'h100};

    tbl[0]  = mkv(3'b010, 1'b0, {5'd0, 5'd5, 5'd0}, {32'd0, 32'hDEAD_BEEF, 32'd0}, 3'b010, 1'b1, 5'd5, 32'hDEAD_BEEF);
    tbl[1]  = mkv(3'b100, 1'b0, {5'd0, 5'd0, 5'd0}, {32'd7, 32'd0, 32'd0},         3'b100, 1'b0, 5'd0, 32'd7);
    tbl[2]  = mkv(3'b111, 1'b0, all_addr, all_data, 3'b001, 1'b1, 5'd1, 32'h100);
    tbl[3]  = mkv(3'b111, 1'b0, all_addr, all_data, 3'b010, 1'b1, 5'd2, 32'h101);
    tbl[4]  = mkv(3'b111, 1'b0, all_addr, all_data, 3'b100, 1'b1, 5'd3, 32'h102);
    tbl[5]  = mkv(3'b111, 1'b0, all_addr, all_data, 3'b001, 1'b1, 5'd1, 32'h100);
    tbl[6]  = mkv(3'b111, 1'b0, all_addr, all_data, 3'b010, 1'b1, 5'd2, 32'h101);
    tbl[7]  = mkv(3'b111, 1'b0, all_addr, all_data, 3'b100, 1'b1, 5'd3, 32'h102);
    tbl[8]  = mkv(3'b001, 1'b1, all_addr, all_data, 3'b000, 1'b0, 5'd3, 32'h102);
    tbl[9]  = mkv(3'b001, 1'b1, all_addr, all_data, 3'b000, 1'b0, 5'd3, 32'h102);
    tbl[10] = mkv(3'b001, 1'b0, all_addr, all_data, 3'b001, 1'b1, 5'd1, 32'h100);
    tbl[11] = mkv(3'b000, 1'b0, all_addr, all_data, 3'b000, 1'b0, 5'd1, 32'h100);

    // Reset with every requester valid: nothing granted, nothing written.
    req_valid = 3'b111; req_addr = all_addr; req_data = all_data;
    #3;
    check("reset_ready", 32'(req_ready), 32'd0);
    check("reset_wr_en", 32'(wr_en), 32'd0);
    @(posedge clk); #1;
    check("reset_wr_en_edge", 32'(wr_en), 32'd0);
    check("reset_wr_addr", 32'(wr_addr), 32'd0);
    check("reset_wr_data", wr_data, 32'd0);
    async_reset = 1'b0;
    #2;
    check("first_grant", 32'(req_ready), 32'b001);
    @(posedge clk); #1;
    check("first_wr_en", 32'(wr_en), 32'd1);
    check("first_wr_addr", 32'(wr_addr), 32'd1);
    $display("[TB] post-reset xfer req=0 addr=%0d data=%0h", wr_addr, wr_data);
    #2;
    check("second_grant", 32'(req_ready), 32'b010);
    @(posedge clk); #1;
    check("second_wr_addr", 32'(wr_addr), 32'd2);

    // Reset asserted between edges while a write is on the port.
    #2;
    async_reset = 1'b1;
    #1;
    check("midrst_wr_en", 32'(wr_en), 32'd0);
    check("midrst_wr_addr", 32'(wr_addr), 32'd0);
    check("midrst_ready", 32'(req_ready), 32'd0);
`ifdef WB_ARB_PERF_EN
    check("midrst_cnt", conflict_cnt, 32'd0);
`endif
    @(posedge clk); #1;
    check("midrst_wr_en_edge", 32'(wr_en), 32'd0);
    async_reset = 1'b0;
    #2;
    check("midrst_ptr0", 32'(req_ready), 32'b001);
    $display("[TB] mid-stream reset: ptr back to 0, write discarded");

    // Directed table starting from ptr=0.
    do_reset();
    for (int i = 0; i < 12; i++) begin
      req_valid = tbl[i].valid; flush = tbl[i].flush;
      req_addr  = tbl[i].addr;  req_data = tbl[i].data;
      #2;
      check($sformatf("tbl%0d_ready", i), 32'(req_ready), 32'(tbl[i].exp_ready));
      @(posedge clk); #1;
      check($sformatf("tbl%0d_wr_en", i), 32'(wr_en), 32'(tbl[i].exp_wr_en));
      check($sformatf("tbl%0d_wr_addr", i), 32'(wr_addr), 32'(tbl[i].exp_wr_addr));
      check($sformatf("tbl%0d_wr_data", i), wr_data, tbl[i].exp_wr_data);
      $display("[TB] vec %0d valid=%b flush=%b -> wr_en=%b addr=%0d data=%0h",
               i, tbl[i].valid, tbl[i].flush, wr_en, wr_addr, wr_data);
    end
`ifdef WB_ARB_PERF_EN
    check("tbl_conflict_cnt", conflict_cnt, 32'd6);
`endif

    // Randomized run: requesters hold valid/addr/data until accepted.
    do_reset();
    pend = '0;
    for (int i = 0; i < N; i++) begin r_addr[i] = '0; r_data[i] = '0; end
    for (int cyc = 0; cyc < 300; cyc++) begin
      int g;
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && ($urandom_range(0, 1) == 1)) begin
          pend[i]   = 1'b1;
          r_addr[i] = ($urandom_range(0, 3) == 0) ? '0 : AW'($urandom_range(0, 31));
          r_data[i] = $urandom;
        end
        req_addr[i*AW +: AW] = r_addr[i];
        req_data[i*DW +: DW] = r_data[i];
      end
      req_valid = pend;
      flush     = ($urandom_range(0, 7) == 0);
      g = flush ? -1 : model_grant(pend, m_ptr);
      #2;
      check("rnd_ready", 32'(req_ready), (g >= 0) ? (32'd1 << g) : 32'd0);
      if (!flush && $countones(pend) >= 2 && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
      if (g >= 0) begin
        m_wr_en   = (r_addr[g] != '0);
        m_wr_addr = r_addr[g];
        m_wr_data = r_data[g];
        m_ptr     = (g + 1) % N;
      end else begin
        m_wr_en = 1'b0;
      end
      @(posedge clk); #1;
      check("rnd_wr_en", 32'(wr_en), 32'(m_wr_en));
      check("rnd_wr_addr", 32'(wr_addr), 32'(m_wr_addr));
      check("rnd_wr_data", wr_data, m_wr_data);
`ifdef WB_ARB_PERF_EN
      check("rnd_conflict_cnt", conflict_cnt, m_cnt);
`endif
      if (g >= 0) begin
        pend[g] = 1'b0;
        $display("[TB] cyc %0d xfer req=%0d addr=%0d data=%08h wr_en=%b", cyc, g, m_wr_addr, m_wr_data, wr_en);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
